// File: rtl/rob_commit_ctrl.sv
// rob_commit_ctrl: reorder buffer with in-order commit, CDB capture, operand queries and mispredict flush
// Define ROB_CDB_BYPASS_EN to forward a same-cycle CDB broadcast to the query ports.
module rob_commit_ctrl #(
  parameter int ROB_DEPTH = 16,
  parameter int TAG_W     = 4,
  parameter int DATA_W    = 32,
  parameter int REG_W     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_reg_dest,
  input  logic              alloc_is_branch,
  output logic              alloc_full,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              cdb_mispredict,
  input  logic [31:0]       cdb_target,
  input  logic [TAG_W-1:0]  q1_tag,
  input  logic [TAG_W-1:0]  q2_tag,
  output logic              q1_ready,
  output logic              q2_ready,
  output logic [DATA_W-1:0] q1_data,
  output logic [DATA_W-1:0] q2_data,
  output logic              commit_valid,
  output logic [REG_W-1:0]  commit_reg_dest,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [DATA_W-1:0] commit_data,
  output logic              flush,
  output logic [31:0]       flush_pc
);
  logic [ROB_DEPTH-1:0] busy_q, ready_q, misp_q;
  logic [REG_W-1:0]     dest_q   [ROB_DEPTH];
  logic [DATA_W-1:0]    data_q   [ROB_DEPTH];
  logic [31:0]          target_q [ROB_DEPTH];
  logic [TAG_W-1:0]     head_q, tail_q;
  logic [TAG_W:0]       count_q, count_d;
  logic                 do_alloc, do_commit, cdb_hit, q1_byp, q2_byp, unused_branch;
  assign unused_branch = alloc_is_branch;
  assign alloc_full = count_q == (TAG_W+1)'(ROB_DEPTH);
  assign alloc_tag  = tail_q;
  assign do_alloc   = alloc_valid && !alloc_full;
  assign do_commit  = count_q != '0 && ready_q[head_q];
  assign cdb_hit    = cdb_valid && busy_q[cdb_tag];
  assign count_d    = count_q + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(do_commit);
`ifdef ROB_CDB_BYPASS_EN
  assign q1_byp = cdb_valid && cdb_tag == q1_tag && busy_q[q1_tag];
  assign q2_byp = cdb_valid && cdb_tag == q2_tag && busy_q[q2_tag];
`else
  assign q1_byp = 1'b0;
  assign q2_byp = 1'b0;
`endif
  assign q1_ready = (busy_q[q1_tag] && ready_q[q1_tag]) || q1_byp;
  assign q2_ready = (busy_q[q2_tag] && ready_q[q2_tag]) || q2_byp;
  assign q1_data  = q1_byp ? cdb_data : data_q[q1_tag];
  assign q2_data  = q2_byp ? cdb_data : data_q[q2_tag];
  // Payload needs no reset: it is only observed through busy/ready.
  always_ff @(posedge clk)
    if (rdy && !rst && !flush) begin
      if (cdb_hit) begin
        data_q[cdb_tag]   <= cdb_data;
        misp_q[cdb_tag]   <= cdb_mispredict;
        target_q[cdb_tag] <= cdb_target;
      end
      if (do_alloc) begin
        dest_q[tail_q] <= alloc_reg_dest;
        misp_q[tail_q] <= 1'b0;
      end
    end
  always_ff @(posedge clk)
    if (rst || flush) begin
      busy_q          <= '0;
      ready_q         <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      commit_valid    <= 1'b0;
      commit_reg_dest <= '0;
      commit_tag      <= '0;
      commit_data     <= '0;
      flush           <= 1'b0;
      flush_pc        <= '0;
    end else if (!rdy) begin
      commit_valid <= 1'b0;
      flush        <= 1'b0;
    end else begin
      commit_valid <= do_commit;
      flush        <= do_commit && misp_q[head_q];
      if (cdb_hit) ready_q[cdb_tag] <= 1'b1;
      if (do_commit) begin
        commit_reg_dest <= dest_q[head_q];
        commit_tag      <= head_q;
        commit_data     <= data_q[head_q];
        if (misp_q[head_q]) flush_pc <= target_q[head_q];
        busy_q[head_q]  <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (do_alloc) begin
        busy_q[tail_q]  <= 1'b1;
        ready_q[tail_q] <= 1'b0;
        tail_q          <= tail_q + 1'b1;
      end
      count_q <= count_d;
    end
endmodule

// File: doc/rob_commit_ctrl.md
Name: rob_commit_ctrl

Overview:
Reorder-buffer controller that sequences in-order retirement into the register file.
- Allocates a reorder tag per decoded instruction and collects out-of-order results from the CDB.
- Retires the head entry once its result is ready, driving the register file's ROB_* write port.
- Answers operand queries from dispatch for tags that are busy in the register file.
- Raises a pipeline flush when a mispredicted branch commits.

Parameters:
ROB_DEPTH, 16, number of entries (power of two)
TAG_W, 4, tag width = log2(ROB_DEPTH)
DATA_W, 32, data width
REG_W, 5, architectural register index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; low freezes all state
alloc_valid  in  1  ID requests an entry this cycle
alloc_reg_dest  in  REG_W  destination register of the instruction (0 = none)
alloc_is_branch  in  1  instruction may mispredict
alloc_full  out  1  buffer cannot accept (combinational)
alloc_tag  out  TAG_W  tag that the next accepted alloc receives (= tail, combinational)
cdb_valid  in  1  result broadcast
cdb_tag  in  TAG_W  producing entry
cdb_data  in  DATA_W  result value
cdb_mispredict  in  1  branch outcome was wrong
cdb_target  in  32  correct PC for a mispredicted branch
q1_tag, q2_tag  in  TAG_W  dispatch operand queries
q1_ready, q2_ready  out  1  queried entry holds its result
q1_data, q2_data  out  DATA_W  queried result
commit_valid  out  1  to regfile ROB_data_valid
commit_reg_dest  out  REG_W  to regfile ROB_reg_dest
commit_tag  out  TAG_W  to regfile ROB_tag
commit_data  out  DATA_W  to regfile ROB_data
flush  out  1  one-cycle clear to regfile, ID, RS and self
flush_pc  out  32  redirect PC

Behaviour:
- Per-entry state: busy, ready, mispredict, reg_dest, data, target. Pointers head and tail are TAG_W bits and wrap modulo ROB_DEPTH. count is TAG_W+1 bits.
- Reset, or flush sampled high: every entry busy=0, head=tail=count=0, and all registered outputs go to 0.
- rdy low: no state changes; commit_valid and flush drive 0 that cycle.
- Allocation happens when alloc_valid && !alloc_full.
  - Entry[tail] is set busy=1, ready=0, mispredict=0, with reg_dest captured.
  - tail advances by 1 and count increments.
  - alloc_full = (count == ROB_DEPTH). An alloc while full is ignored and ID must hold.
- CDB capture: cdb_valid writes data, mispredict and target into entry[cdb_tag] and sets ready=1. A CDB write to a non-busy entry is ignored.
- Commit is evaluated from registered state. If count>0 and entry[head].ready:
  - Next cycle commit_valid=1, with commit_reg_dest/tag/data taken from the head entry.
  - busy is cleared, head advances, and count decrements.
  - A result arriving on the CDB for the head entry commits no earlier than the following cycle, so commit latency is 1 cycle after capture.
  - At most one commit per cycle.
- Simultaneous alloc and commit: count unchanged, both pointers advance.
- Full wrap: tail == head with count == ROB_DEPTH is full; with count == 0 it is empty.
- Misprediction: a committing head with mispredict=1 still writes its reg_dest (JAL/JALR link).
  - In the same output cycle flush=1 and flush_pc=target.
  - The next cycle applies the reset state above; allocs and CDB writes in that cycle are discarded.
- Query ports are combinational: qN_ready = busy[qN_tag] && ready[qN_tag], and qN_data = data[qN_tag].
- reg_dest 0 entries still commit with commit_reg_dest=0; the regfile ignores the write.

Optional Feature:
ROB_CDB_BYPASS_EN
- Defined: if cdb_valid && cdb_tag == qN_tag and the entry is busy, then qN_ready=1 and qN_data=cdb_data in the same cycle, so dispatch does not miss a broadcast.
- Undefined: queries see only registered entry state, and the value becomes visible the cycle after capture.

Test Plan:
- Reset, then alloc 3 entries (rd=1,2,3) → alloc_tag 0,1,2; count=3; commit_valid=0.
- CDB tag 1 data 0xAA, then tag 0 data 0x55 → commits tag0/rd1/0x55, then tag1/rd2/0xAA on consecutive cycles; tag2 is held.
- Alloc 16 without any CDB writes → alloc_full=1 and the 17th alloc is ignored. Complete tag 0 → alloc_full drops after the commit, and the next alloc_tag is 0 (wrap).
- Branch at tag 5 completes with cdb_mispredict=1 and target 0x1000 while tags 6-8 are busy → at its commit flush=1 and flush_pc=0x1000. Next cycle count=0, and a tag-6 CDB write is discarded.
- q1_tag=4 with a CDB write to tag 4 of 0x77 in the same cycle → with ROB_CDB_BYPASS_EN, q1_ready=1 and q1_data=0x77 that cycle; without it, q1_ready=0 that cycle and 1 the next.
- rdy low for 3 cycles while the head is ready → no commit; the commit appears one cycle after rdy returns high.
